serial_sub: RTL

//  Bit-serial WIDTH-bit unsigned subtractor DIFF = A - B: the inverse-operation

---
 rtl/serial_sub_if.sv | 32 +++
 rtl/serial_sub.sv | 123 ++++++++++++
 2 files changed

// File: rtl/serial_sub_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
// The ovf signal exists only when OVF_FLAG_EN is defined.
interface serial_sub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] DIFF;
  logic             b_out;
`ifdef OVF_FLAG_EN
  logic             ovf;
`endif

  modport master (
    output start, A, B,
    input  busy, done, DIFF, b_out
`ifdef OVF_FLAG_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, A, B,
    output busy, done, DIFF, b_out
`ifdef OVF_FLAG_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor DIFF = A - B, one full-subtractor cell per clock, LSB first.
// Optional OVF_FLAG_EN adds a registered two's-complement overflow flag.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_sub_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             res_bit_d;
  logic             borrow_d;
`ifdef OVF_FLAG_EN
  logic             a_msb_q;
  logic             b_msb_q;
  logic             ovf_q;
`endif

  // Full-subtractor cell on the current LSBs of the operand shift registers
  always_comb begin
    res_bit_d = a_q[0] ^ b_q[0] ^ borrow_q;
    borrow_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
  end

  // Control FSM, operand/result shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      cnt_q    <= {CW{1'b0}};
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      bout_q   <= 1'b0;
`ifdef OVF_FLAG_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            res_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            borrow_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
`ifdef OVF_FLAG_EN
            a_msb_q  <= bus.A[WIDTH-1];
            b_msb_q  <= bus.B[WIDTH-1];
`endif
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q      <= {1'b0, a_q[WIDTH-1:1]};
          b_q      <= {1'b0, b_q[WIDTH-1:1]};
          res_q    <= {res_bit_d, res_q[WIDTH-1:1]};
          borrow_q <= borrow_d;
          // The last cell output is folded straight into DIFF rather than waiting a cycle
          if (cnt_q == CW'(WIDTH - 1)) begin
            diff_q  <= {res_bit_d, res_q[WIDTH-1:1]};
            bout_q  <= borrow_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef OVF_FLAG_EN
            ovf_q   <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_bit_d);
`endif
          end else begin
            cnt_q   <= cnt_q + CW'(1);
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.DIFF  = diff_q;
  assign bus.b_out = bout_q;
`ifdef OVF_FLAG_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule
